ray_tri_scheduler: RTL and testbench
====================================

// Module: ray_tri_scheduler
// PURPOSE
//  Upstream sequencer for the combinational intersect stage. Accepts one ray
//  and a triangle count, then fetches triangles 0..count-1 from triangle
//  memory. Each triangle is registered and presented with the ray to
//  intersect, whose result/invalid flags are sampled. Emits a per-ray summary:
//  any-hit flag, first-hit index, hit count and invalid count.
// PARAMETERS
//  IDX_W    16  width of triangle index / count / counters
//  MEM_LAT  1   triangle memory read latency in cycles (legal 1..4)
// PORTS
//  i_clk            in   1        clock; all state on rising edge
//  i_reset          in   1        synchronous, active-high reset
//  i_ray_valid      in   1        ray request valid
//  o_ray_ready      out  1        scheduler can accept a ray (high only in IDLE)
//  i_ray            in   2x3x32   [1]=origin, [0]=direction, signed fixed point
//  i_tri_count      in   IDX_W    number of triangles to test for this ray
//  o_mem_rd_en      out  1        triangle read strobe
//  o_mem_addr       out  IDX_W    triangle index to read
//  i_mem_data       in   3x3x32   triangle corners; valid MEM_LAT cycles after rd_en
//  o_ix_triangle    out  3x3x32   registered triangle to intersect
//  o_ix_ray         out  2x3x32   registered ray to intersect
//  i_ix_result      in   1        intersect hit flag (combinational from o_ix_*)
//  i_ix_invalid     in   1        intersect overflow/div-by-0 flag
//  o_done_valid     out  1        summary valid
//  i_done_ready     in   1        consumer accepts summary
//  o_hit            out  1        at least one valid hit
//  o_hit_idx        out  IDX_W    lowest index with a valid hit (0 if none)
//  o_hit_count      out  IDX_W    valid hits, saturating at all-ones
//  o_invalid_count  out  IDX_W    invalid evaluations, saturating at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; o_ray_ready=1; o_mem_rd_en=0; o_done_valid=0;
//   o_hit=0; o_mem_addr, o_hit_idx, both counts, o_ix_triangle, o_ix_ray = 0.
//  FSM IDLE -> FETCH -> WAIT -> EVAL -> (FETCH | DONE); DONE -> IDLE.
//  - IDLE: ray accepted on i_ray_valid & o_ray_ready; latch ray into o_ix_ray
//    and latch count; clear idx, hit, hit_idx, counts. Next state is FETCH if
//    count != 0, else DONE (all-zero summary).
//  - FETCH (1 cycle): o_mem_rd_en=1, o_mem_addr=idx.
//  - WAIT (MEM_LAT cycles): on the edge ending cycle FETCH+MEM_LAT, capture
//    i_mem_data into o_ix_triangle.
//  - EVAL (1 cycle): sample i_ix_result/i_ix_invalid.
//    * Invalid: invalid_count+1 (saturating); not a hit, even if result=1.
//    * Valid result=1: hit_count+1 (saturating); if o_hit==0, set o_hit=1
//      and o_hit_idx=idx.
//    Then if idx==count-1 go DONE, else idx+1 and go FETCH.
//  - DONE: o_done_valid=1; summary outputs held stable until
//    o_done_valid & i_done_ready, then go IDLE (o_ray_ready=1 next cycle).
//  Timing: MEM_LAT+2 cycles per triangle; o_done_valid rises exactly
//   N*(MEM_LAT+2)+1 cycles after the accept edge (N=count; N=0 -> 1 cycle).
//  o_ix_ray and o_ix_triangle are constant through EVAL; o_ix_ray is constant
//   from accept until the next accept.
//  i_ray/i_tri_count are ignored outside IDLE. i_mem_data is ignored except at
//   the capture edge.
//  Count = 2^IDX_W-1: idx does not wrap; the final triangle is index count-1.
//  Reset mid-operation: return to IDLE with reset values; in-flight memory data
//   is ignored and the summary is discarded.
// TESTING
//  1 MEM_LAT=1, count=4, stub result=1 only at idx 2 -> done at cycle 13;
//    hit=1, hit_idx=2, hit_count=1, invalid_count=0.
//  2 count=0 -> no rd_en, done_valid 1 cycle after accept, all summary fields 0.
//  3 count=5, result=1 at idx 1,3; invalid=1 at idx 1 and 4 -> hit_idx=3,
//    hit_count=1, invalid_count=2.
//  4 MEM_LAT=3, count=3, distinct corner data per addr -> rd_en addrs 0,1,2
//    every 5 cycles; o_ix_triangle matches addr data in each EVAL; done at
//    cycle 16.
//  5 hold i_done_ready=0 for 10 cycles in DONE -> outputs stable,
//    o_ray_ready=0; then ready=1 -> IDLE and new ray accepted next cycle.
//  6 assert reset in WAIT of idx 2 -> next cycle all reset values;
//    stale i_mem_data does not change o_ix_triangle; new ray runs normally.

Source files
------------

// File: rtl/ray_tri_scheduler.sv
// Sequencer for the intersect stage. It fetches triangles 0..count-1 for one ray,
// registers each triangle for the intersect stage, and reduces the hit/invalid flags into a per-ray summary.
module ray_tri_scheduler #(
  parameter int IDX_W   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_ray_valid,
  output logic                        o_ray_ready,
  input  logic [1:0][2:0][31:0]       i_ray,
  input  logic [IDX_W-1:0]            i_tri_count,
  output logic                        o_mem_rd_en,
  output logic [IDX_W-1:0]            o_mem_addr,
  input  logic [2:0][2:0][31:0]       i_mem_data,
  output logic [2:0][2:0][31:0]       o_ix_triangle,
  output logic [1:0][2:0][31:0]       o_ix_ray,
  input  logic                        i_ix_result,
  input  logic                        i_ix_invalid,
  output logic                        o_done_valid,
  input  logic                        i_done_ready,
  output logic                        o_hit,
  output logic [IDX_W-1:0]            o_hit_idx,
  output logic [IDX_W-1:0]            o_hit_count,
  output logic [IDX_W-1:0]            o_invalid_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] SAT       = '1;
  localparam logic [2:0]       WAIT_INIT = 3'(MEM_LAT - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] count;
  logic [2:0]       wait_cnt;

  // The read address is the index register itself, so it stays stable through WAIT.
  assign o_mem_addr = idx;

  // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the wide datapath registers are reset too because their reset value is observable.
      state           <= S_IDLE;
      idx             <= '0;
      count           <= '0;
      wait_cnt        <= '0;
      o_ray_ready     <= 1'b1;
      o_mem_rd_en     <= 1'b0;
      o_done_valid    <= 1'b0;
      o_hit           <= 1'b0;
      o_hit_idx       <= '0;
      o_hit_count     <= '0;
      o_invalid_count <= '0;
      o_ix_triangle   <= '0;
      o_ix_ray        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ray_valid) begin
            o_ix_ray        <= i_ray;
            count           <= i_tri_count;
            idx             <= '0;
            o_hit           <= 1'b0;
            o_hit_idx       <= '0;
            o_hit_count     <= '0;
            o_invalid_count <= '0;
            o_ray_ready     <= 1'b0;
            if (i_tri_count != '0) begin
              o_mem_rd_en <= 1'b1;
              state       <= S_FETCH;
            end else begin
              o_done_valid <= 1'b1;
              state        <= S_DONE;
            end
          end
        end

        S_FETCH: begin
          o_mem_rd_en <= 1'b0;
          wait_cnt    <= WAIT_INIT;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            o_ix_triangle <= i_mem_data;
            state         <= S_EVAL;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        S_EVAL: begin
          // An invalid evaluation never counts as a hit, whatever the result flag says.
          if (i_ix_invalid) begin
            if (o_invalid_count != SAT) o_invalid_count <= o_invalid_count + 1'b1;
          end else if (i_ix_result) begin
            if (o_hit_count != SAT) o_hit_count <= o_hit_count + 1'b1;
            if (!o_hit) begin
              o_hit     <= 1'b1;
              o_hit_idx <= idx;
            end
          end
          if (idx == count - 1'b1) begin
            o_done_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            idx         <= idx + 1'b1;
            o_mem_rd_en <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_DONE: begin
          if (i_done_ready) begin
            o_done_valid <= 1'b0;
            o_ray_ready  <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_tri_scheduler.sv
// Bench for ray_tri_scheduler. It drives two instances (MEM_LAT 1 and 3), each with a behavioural triangle memory
// and an intersect stub. A cycle-level model predicts every output from the ray/triangle schedule.
module tb_ray_tri_scheduler;

  typedef logic [2:0][2:0][31:0] tri_t;
  typedef logic [1:0][2:0][31:0] ray_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ray_valid  [2];
  logic        ray_ready  [2];
  ray_t        ray_in     [2];
  logic [15:0] tri_count  [2];
  logic        rd_en      [2];
  logic [15:0] addr       [2];
  tri_t        mem_data   [2];
  tri_t        ix_tri     [2];
  ray_t        ix_ray     [2];
  logic        ix_result  [2];
  logic        ix_invalid [2];
  logic        done_valid [2];
  logic        done_ready [2];
  logic        hit        [2];
  logic [15:0] hit_idx    [2];
  logic [15:0] hit_count  [2];
  logic [15:0] inv_count  [2];

  logic [63:0] hit_tab = '0;
  logic [63:0] inv_tab = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ray_tri_scheduler #(.IDX_W(16), .MEM_LAT(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_ray_valid(ray_valid[0]), .o_ray_ready(ray_ready[0]),
    .i_ray(ray_in[0]), .i_tri_count(tri_count[0]), .o_mem_rd_en(rd_en[0]), .o_mem_addr(addr[0]),
    .i_mem_data(mem_data[0]), .o_ix_triangle(ix_tri[0]), .o_ix_ray(ix_ray[0]),
    .i_ix_result(ix_result[0]), .i_ix_invalid(ix_invalid[0]), .o_done_valid(done_valid[0]),
    .i_done_ready(done_ready[0]), .o_hit(hit[0]), .o_hit_idx(hit_idx[0]),
    .o_hit_count(hit_count[0]), .o_invalid_count(inv_count[0]));

  ray_tri_scheduler #(.IDX_W(16), .MEM_LAT(3)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_ray_valid(ray_valid[1]), .o_ray_ready(ray_ready[1]),
    .i_ray(ray_in[1]), .i_tri_count(tri_count[1]), .o_mem_rd_en(rd_en[1]), .o_mem_addr(addr[1]),
    .i_mem_data(mem_data[1]), .o_ix_triangle(ix_tri[1]), .o_ix_ray(ix_ray[1]),
    .i_ix_result(ix_result[1]), .i_ix_invalid(ix_invalid[1]), .o_done_valid(done_valid[1]),
    .i_done_ready(done_ready[1]), .o_hit(hit[1]), .o_hit_idx(hit_idx[1]),
    .o_hit_count(hit_count[1]), .o_invalid_count(inv_count[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Triangle contents encode their own index in the top half of every word.
  function automatic tri_t tri_data(input logic [15:0] a);
    tri_t t;
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++)
        t[c][j] = {a, 4'(c), 4'(j), 8'h5A};
    return t;
  endfunction

  function automatic ray_t make_ray(input int seed);
    ray_t r;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        r[a][b] = 32'(seed * 16 + a * 3 + b) ^ 32'h8000_0000;
    return r;
  endfunction

  // Memory: data is valid exactly MEM_LAT cycles after rd_en, garbage otherwise.
  logic [3:0]  pv [2];
  logic [15:0] pa [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pv[k] <= {pv[k][2:0], rd_en[k]};
      pa[k][0] <= addr[k];
      for (int s = 1; s < 4; s++) pa[k][s] <= pa[k][s-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ti;
      mem_data[k] = pv[k][lat_of(k)-1] ? tri_data(pa[k][lat_of(k)-1]) : {9{32'hDEAD_BEEF}};
      ti = ix_tri[k][0][0][31:16];
      ix_result[k]  = (ti < 16'd64) ? hit_tab[ti[5:0]] : 1'b0;
      ix_invalid[k] = (ti < 16'd64) ? inv_tab[ti[5:0]] : 1'b0;
    end
  end

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per ray, triangle i is fetched at cycle 1+i*(L+2), evaluated at (i+1)*(L+2), and
  // the summary appears at N*(L+2)+1 (cycles counted from the accept edge).
  bit          m_busy [2];
  int          m_rel  [2];
  int          m_n    [2];
  ray_t        m_ray  [2];
  logic        m_hit  [2];
  logic [15:0] m_hidx [2];
  logic [15:0] m_hc   [2];
  logic [15:0] m_ic   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0;
        m_ray[k]  = '0;
      end else if (!m_busy[k]) begin
        if (ray_valid[k]) begin
          m_busy[k] = 1'b1;
          m_rel[k]  = 1;
          m_n[k]    = int'(tri_count[k]);
          m_ray[k]  = ray_in[k];
          m_hit[k]  = 1'b0;
          m_hidx[k] = '0;
          m_hc[k]   = '0;
          m_ic[k]   = '0;
          for (int i = 0; i < m_n[k]; i++) begin
            if (inv_tab[i]) m_ic[k]++;
            else if (hit_tab[i]) begin
              if (!m_hit[k]) m_hidx[k] = 16'(i);
              m_hit[k] = 1'b1;
              m_hc[k]++;
            end
          end
        end
      end else if (m_rel[k] >= m_n[k] * (lat_of(k) + 2) + 1 && done_ready[k]) begin
        m_busy[k] = 1'b0;
      end else begin
        m_rel[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int  l2, rel, span;
        bit  e_done, e_rd, e_eval;
        l2     = lat_of(k) + 2;
        rel    = m_rel[k];
        span   = m_n[k] * l2;
        e_done = m_busy[k] && rel >= span + 1;
        e_rd   = m_busy[k] && rel <= span && ((rel - 1) % l2 == 0);
        e_eval = m_busy[k] && rel <= span && (rel % l2 == 0);
        check($sformatf("u%0d ray_ready", k), ray_ready[k], !m_busy[k]);
        check($sformatf("u%0d done_valid", k), done_valid[k], e_done);
        check($sformatf("u%0d rd_en", k), rd_en[k], e_rd);
        check($sformatf("u%0d ix_ray", k), ix_ray[k], m_ray[k]);
        if (e_rd) check($sformatf("u%0d mem_addr", k), addr[k], 16'((rel - 1) / l2));
        if (e_eval) check($sformatf("u%0d ix_triangle", k), ix_tri[k], tri_data(16'(rel / l2 - 1)));
        if (e_done) begin
          check($sformatf("u%0d hit", k), hit[k], m_hit[k]);
          check($sformatf("u%0d hit_idx", k), hit_idx[k], m_hidx[k]);
          check($sformatf("u%0d hit_count", k), hit_count[k], m_hc[k]);
          check($sformatf("u%0d invalid_count", k), inv_count[k], m_ic[k]);
        end
      end
    end
  end

  task automatic accept(input int k, input int n, input int seed);
    @(posedge clk); #2;
    ray_in[k]    = make_ray(seed);
    tri_count[k] = 16'(n);
    ray_valid[k] = 1'b1;
    @(posedge clk); #2;
    ray_valid[k] = 1'b0;
    ray_in[k]    = make_ray(999);
    tri_count[k] = 16'hFFFF;
  endtask

  // Issue a ray, then pin the latency and summary to hand-computed literals.
  task automatic run_ray(input int k, input int n, input int seed, input int exp_cyc,
                         input logic e_hit, input int e_idx, input int e_hc, input int e_ic);
    int c;
    accept(k, n, seed);
    c = 0;
    while (c < 600) begin
      @(negedge clk);
      c++;
      if (done_valid[k]) break;
    end
    check($sformatf("u%0d done latency", k), c, exp_cyc);
    check($sformatf("u%0d lit hit", k), hit[k], e_hit);
    check($sformatf("u%0d lit hit_idx", k), hit_idx[k], e_idx);
    check($sformatf("u%0d lit hit_count", k), hit_count[k], e_hc);
    check($sformatf("u%0d lit invalid_count", k), inv_count[k], e_ic);
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s u%0d ray_ready", tag, k), ray_ready[k], 1'b1);
      check($sformatf("%s u%0d rd_en", tag, k), rd_en[k], 1'b0);
      check($sformatf("%s u%0d done_valid", tag, k), done_valid[k], 1'b0);
      check($sformatf("%s u%0d hit", tag, k), hit[k], 1'b0);
      check($sformatf("%s u%0d mem_addr", tag, k), addr[k], 16'd0);
      check($sformatf("%s u%0d hit_idx", tag, k), hit_idx[k], 16'd0);
      check($sformatf("%s u%0d hit_count", tag, k), hit_count[k], 16'd0);
      check($sformatf("%s u%0d invalid_count", tag, k), inv_count[k], 16'd0);
      check($sformatf("%s u%0d ix_triangle", tag, k), ix_tri[k], 288'd0);
      check($sformatf("%s u%0d ix_ray", tag, k), ix_ray[k], 192'd0);
    end
  endtask

  initial begin
    int c;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ray_valid[k]  = 1'b0;
      done_ready[k] = 1'b1;
      ray_in[k]     = '0;
      tri_count[k]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #2;
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Single hit at index 2, MEM_LAT=1.
    hit_tab = 64'h4; inv_tab = 64'h0;
    run_ray(0, 4, 1, 13, 1'b1, 2, 1, 0);

    // Empty ray: immediate all-zero summary.
    run_ray(0, 0, 2, 1, 1'b0, 0, 0, 0);

    // Invalid at idx 1 masks its result; first valid hit is idx 3.
    hit_tab = 64'h0A; inv_tab = 64'h12;
    run_ray(0, 5, 3, 16, 1'b1, 3, 1, 2);

    // MEM_LAT=3: five cycles per triangle.
    hit_tab = 64'h2; inv_tab = 64'h0;
    run_ray(1, 3, 4, 16, 1'b1, 1, 1, 0);

    // Back-pressure on the summary, then back-to-back ray.
    hit_tab = 64'h3; inv_tab = 64'h0;
    done_ready[0] = 1'b0;
    run_ray(0, 2, 5, 7, 1'b1, 0, 2, 0);
    repeat (10) @(negedge clk);
    check("held ray_ready", ray_ready[0], 1'b0);
    check("held done_valid", done_valid[0], 1'b1);
    check("held hit_count", hit_count[0], 16'd2);
    @(posedge clk); #2;
    done_ready[0] = 1'b1;
    run_ray(0, 1, 6, 4, 1'b1, 0, 1, 0);

    // Reset in the WAIT cycle of idx 2 (cycle 8 with MEM_LAT=1).
    hit_tab = 64'h8; inv_tab = 64'h0;
    accept(0, 4, 7);
    c = 0;
    while (c < 8) begin
      @(negedge clk);
      c++;
    end
    check("pre-reset addr", addr[0], 16'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset ix_triangle", ix_tri[0], 288'd0);
    run_ray(0, 4, 8, 13, 1'b1, 3, 1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
